// File: rtl/mem_access_unit.sv
// MEM-stage data-bus access unit: aligns loads and stores, runs one bus
// transaction per instruction with a wait timeout and flush handling.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_Mem,
  input  logic        MemWrite_Mem,
  input  logic [1:0]  MemSize_Mem,
  input  logic        MemSigned_Mem,
  input  logic [31:0] Addr_Mem,
  input  logic [31:0] StoreData_Mem,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] MemData_Mem,
  output logic [3:0]  Rd_write_byte_en_Mem,
  output logic        mem_stall,
  output logic        addr_exc,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          drop;
  logic          ld_q;
  logic          sgn_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;

  logic        req;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        mis;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] ld_data;

  assign req  = (MemRead_Mem | MemWrite_Mem) & ~flush;
  assign is_b = (MemSize_Mem == 2'b00);
  assign is_h = (MemSize_Mem == 2'b01);
  assign is_w = MemSize_Mem[1];
  assign mis  = (is_h & Addr_Mem[0]) | (is_w & (|Addr_Mem[1:0]));

  assign mem_stall = rst_n & (((state == IDLE) & req & ~mis) |
                              (state == ACCESS));
  assign addr_exc  = rst_n & (state == IDLE) & req & mis;

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = StoreData_Mem;
    unique case (1'b1)
      is_b: begin
        be_n    = 4'b0001 << Addr_Mem[1:0];
        wdata_n = {4{StoreData_Mem[7:0]}};
      end
      is_h: begin
        be_n    = 4'b0011 << {Addr_Mem[1], 1'b0};
        wdata_n = {2{StoreData_Mem[15:0]}};
      end
      is_w: begin
        be_n    = 4'b1111;
        wdata_n = StoreData_Mem;
      end
    endcase
  end

  // Lane selection uses the offset captured at launch, not the live address.
  always_comb begin
    rd_b    = 8'(bus_rdata >> {lane_q, 3'b000});
    rd_h    = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ld_data = bus_rdata;
    unique case (1'b1)
      size_q == 2'b00: ld_data = {{24{sgn_q & rd_b[7]}}, rd_b};
      size_q == 2'b01: ld_data = {{16{sgn_q & rd_h[15]}}, rd_h};
      size_q[1]:       ld_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      drop                 <= 1'b0;
      ld_q                 <= 1'b0;
      sgn_q                <= 1'b0;
      lane_q               <= 2'b00;
      size_q               <= 2'b00;
      bus_req              <= 1'b0;
      bus_we               <= 1'b0;
      bus_addr             <= '0;
      bus_be               <= '0;
      bus_wdata            <= '0;
      MemData_Mem          <= '0;
      Rd_write_byte_en_Mem <= '0;
      bus_err              <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && !mis) begin
            bus_req   <= 1'b1;
            bus_we    <= ~MemRead_Mem;
            bus_addr  <= {Addr_Mem[31:2], 2'b00};
            bus_be    <= be_n;
            bus_wdata <= wdata_n;
            lane_q    <= Addr_Mem[1:0];
            size_q    <= MemSize_Mem;
            sgn_q     <= MemSigned_Mem;
            ld_q      <= MemRead_Mem;
            cnt       <= '0;
            drop      <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            drop    <= 1'b0;
            // A flush on the ack cycle itself also discards the result.
            if (drop || flush) begin
              MemData_Mem          <= '0;
              Rd_write_byte_en_Mem <= 4'b0000;
              state                <= IDLE;
            end else begin
              MemData_Mem          <= ld_q ? ld_data : 32'd0;
              Rd_write_byte_en_Mem <= ld_q ? 4'b1111 : 4'b0000;
              state                <= DONE;
            end
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            bus_req              <= 1'b0;
            bus_err              <= 1'b1;
            drop                 <= 1'b0;
            MemData_Mem          <= '0;
            Rd_write_byte_en_Mem <= 4'b0000;
            state                <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
            if (flush) drop <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; load/store results are queued
// at launch and compared when the unit completes.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead_Mem = 1'b0;
  logic        MemWrite_Mem = 1'b0;
  logic [1:0]  MemSize_Mem = 2'b00;
  logic        MemSigned_Mem = 1'b0;
  logic [31:0] Addr_Mem = '0;
  logic [31:0] StoreData_Mem = '0;
  logic        flush = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] MemData_Mem;
  logic [3:0]  Rd_write_byte_en_Mem;
  logic        mem_stall;
  logic        addr_exc;
  logic        bus_err;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .MemRead_Mem          (MemRead_Mem),
    .MemWrite_Mem         (MemWrite_Mem),
    .MemSize_Mem          (MemSize_Mem),
    .MemSigned_Mem        (MemSigned_Mem),
    .Addr_Mem             (Addr_Mem),
    .StoreData_Mem        (StoreData_Mem),
    .flush                (flush),
    .bus_req              (bus_req),
    .bus_we               (bus_we),
    .bus_addr             (bus_addr),
    .bus_be               (bus_be),
    .bus_wdata            (bus_wdata),
    .bus_ack              (bus_ack),
    .bus_rdata            (bus_rdata),
    .MemData_Mem          (MemData_Mem),
    .Rd_write_byte_en_Mem (Rd_write_byte_en_Mem),
    .mem_stall            (mem_stall),
    .addr_exc             (addr_exc),
    .bus_err              (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    MemRead_Mem   = 1'b0;
    MemWrite_Mem  = 1'b0;
    MemSize_Mem   = 2'b00;
    MemSigned_Mem = 1'b0;
    Addr_Mem      = '0;
    StoreData_Mem = '0;
  endtask

  task automatic issue(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    MemRead_Mem   = rd;
    MemWrite_Mem  = wr;
    MemSize_Mem   = sz;
    MemSigned_Mem = sg;
    Addr_Mem      = a;
    StoreData_Mem = d;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] be,
                      input logic err);
    exp_t e;
    e.data = d;
    e.be   = be;
    e.err  = err;
    q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errs++;
      $error("FAIL %s observed=completion expected=none_queued", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_data"}, MemData_Mem, e.data);
      chk({tag, "_ben"}, {28'd0, Rd_write_byte_en_Mem}, {28'd0, e.be});
      chk({tag, "_err"}, {31'd0, bus_err}, {31'd0, e.err});
    end
  endtask

  initial begin
    int n;
    #1;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_data", MemData_Mem, 32'd0);
    chk("rst_ben", {28'd0, Rd_write_byte_en_Mem}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // lb signed from lane 3, ack on the third ACCESS cycle
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'd0);
    #1;
    chk("lb_stall_idle", {31'd0, mem_stall}, 32'd1);
    chk("lb_exc", {31'd0, addr_exc}, 32'd0);
    push(32'hFFFF_FF80, 4'b1111, 1'b0);
    step();
    clr();
    chk("lb_req", {31'd0, bus_req}, 32'd1);
    chk("lb_addr", bus_addr, 32'h0000_1000);
    chk("lb_be", {28'd0, bus_be}, 32'h8);
    chk("lb_we", {31'd0, bus_we}, 32'd0);
    chk("lb_stall_a1", {31'd0, mem_stall}, 32'd1);
    step();
    chk("lb_stall_a2", {31'd0, mem_stall}, 32'd1);
    step();
    chk("lb_stall_a3", {31'd0, mem_stall}, 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h80FF_FF12;
    step();
    chk("lb_done_stall", {31'd0, mem_stall}, 32'd0);
    chk("lb_done_req", {31'd0, bus_req}, 32'd0);
    pop_chk("lb");
    // next instruction offered during DONE; ack left high is ignored
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    #1;
    chk("done_stall_req", {31'd0, mem_stall}, 32'd0);
    step();
    bus_ack = 1'b0;
    chk("lb_hold_data", MemData_Mem, 32'hFFFF_FF80);
    chk("idle_req", {31'd0, bus_req}, 32'd0);
    chk("sh_stall_idle", {31'd0, mem_stall}, 32'd1);

    // sh to upper half
    step();
    clr();
    push(32'd0, 4'b0000, 1'b0);
    chk("sh_be", {28'd0, bus_be}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    chk("sh_we", {31'd0, bus_we}, 32'd1);
    chk("sh_addr", bus_addr, 32'h0000_2000);
    step();
    chk("sh_addr_stable", bus_addr, 32'h0000_2000);
    chk("sh_be_stable", {28'd0, bus_be}, 32'hC);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    pop_chk("sh");
    step();

    // misaligned lw
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0);
    #1;
    chk("lw_mis_exc", {31'd0, addr_exc}, 32'd1);
    chk("lw_mis_stall", {31'd0, mem_stall}, 32'd0);
    step();
    chk("lw_mis_req", {31'd0, bus_req}, 32'd0);
    chk("lw_mis_exc_idle", {31'd0, addr_exc}, 32'd1);
    clr();
    #1;
    chk("exc_clear", {31'd0, addr_exc}, 32'd0);

    // lhu flushed in its second ACCESS cycle
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'd0);
    step();
    clr();
    push(32'd0, 4'b0000, 1'b0);
    chk("lhu_req", {31'd0, bus_req}, 32'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("lhu_req_after_flush", {31'd0, bus_req}, 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h8001_0000;
    step();
    bus_ack = 1'b0;
    pop_chk("lhu_drop");
    chk("lhu_req_off", {31'd0, bus_req}, 32'd0);
    // a fresh request stalls at once, so the unit is back in IDLE
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'd0);
    #1;
    chk("drop_to_idle", {31'd0, mem_stall}, 32'd1);

    // lw with no ack until the timeout
    step();
    clr();
    chk("to_req", {31'd0, bus_req}, 32'd1);
    n = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_req) n++;
      else break;
    end
    chk("to_req_cycles", 32'(n), 32'd4);
    push(32'd0, 4'b0000, 1'b1);
    pop_chk("timeout");
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'd0);
    #1;
    chk("to_done_stall", {31'd0, mem_stall}, 32'd0);
    step();
    chk("to_err_pulse", {31'd0, bus_err}, 32'd0);
    chk("lh_stall_idle", {31'd0, mem_stall}, 32'd1);

    // lh signed from the upper half, immediate ack
    step();
    clr();
    bus_ack   = 1'b1;
    bus_rdata = 32'h8001_0000;
    push(32'hFFFF_8001, 4'b1111, 1'b0);
    step();
    bus_ack = 1'b0;
    pop_chk("lh");
    step();

    // sb then asynchronous reset in the middle of ACCESS
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'h0000_00A5);
    step();
    clr();
    chk("sb_be", {28'd0, bus_be}, 32'h2);
    chk("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
    #3;
    rst_n = 1'b0;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0);
    #1;
    chk("arst_req", {31'd0, bus_req}, 32'd0);
    chk("arst_stall", {31'd0, mem_stall}, 32'd0);
    chk("arst_exc", {31'd0, addr_exc}, 32'd0);
    chk("arst_addr", bus_addr, 32'd0);
    chk("arst_be", {28'd0, bus_be}, 32'd0);
    chk("arst_wdata", bus_wdata, 32'd0);
    chk("arst_we", {31'd0, bus_we}, 32'd0);
    chk("arst_data", MemData_Mem, 32'd0);
    chk("arst_ben", {28'd0, Rd_write_byte_en_Mem}, 32'd0);
    chk("arst_err", {31'd0, bus_err}, 32'd0);
    clr();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_req", {31'd0, bus_req}, 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum ACCESS cycles to wait for bus_ack before aborting.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port MemRead_Mem, input, 1: load in MEM stage.
REQ-005 SHALL have port MemWrite_Mem, input, 1: store in MEM stage.
REQ-006 SHALL have port MemSize_Mem, input, 2: access size; 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 SHALL have port MemSigned_Mem, input, 1: load sign-extension enable.
REQ-008 SHALL have port Addr_Mem, input, 32: byte address.
REQ-009 SHALL have port StoreData_Mem, input, 32: store data, right-justified.
REQ-010 SHALL have port flush, input, 1: kill the MEM-stage instruction.
REQ-011 SHALL have outputs bus_req (1), bus_we (1), bus_addr (32), bus_be (4) and bus_wdata (32): registered data-bus request.
REQ-012 SHALL have inputs bus_ack (1) and bus_rdata (32): bus completion and read data.
REQ-013 SHALL have outputs MemData_Mem (32) and Rd_write_byte_en_Mem (4): registered load result and register-write byte enables for the MEM/WB register.
REQ-014 SHALL have outputs mem_stall (1), addr_exc (1) and bus_err (1): pipeline hold, misalignment flag and timeout pulse.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-016 Request condition: (MemRead_Mem|MemWrite_Mem) & !flush; MemRead_Mem takes priority if both are high.
REQ-017 Misaligned: half with Addr_Mem[0]=1, or word with Addr_Mem[1:0]!=0.
REQ-018 IDLE, request and aligned: next edge registers bus_req=1, bus_we=store, bus_addr={Addr[31:2],2'b00}, bus_be, bus_wdata, lane and size/sign info; go to ACCESS.
REQ-019 IDLE, request but misaligned: addr_exc=1 combinationally, no bus access, mem_stall=0, stay in IDLE.
REQ-020 mem_stall SHALL be 1 combinationally in IDLE with an aligned request and throughout ACCESS, and 0 in DONE and otherwise.
REQ-021 Byte enables: byte 4'b0001<<Addr[1:0]; half 4'b0011<<{Addr[1],1'b0}; word 4'b1111.
REQ-022 Write data: byte {4{StoreData[7:0]}}; half {2{StoreData[15:0]}}; word StoreData.
REQ-023 ACCESS with bus_ack=1: next edge clears bus_req, captures the aligned load or zero for a store into MemData_Mem, sets Rd_write_byte_en_Mem=4'b1111 for a load and 4'b0000 for a store, and goes to DONE.
REQ-024 Load alignment: byte = bus_rdata[8*lane+7 -: 8] and half = bus_rdata[16*Addr[1]+15 -: 16], zero- or sign-extended per MemSigned.
REQ-025 DONE SHALL last exactly one cycle with outputs held, then go to IDLE; the next instruction is evaluated in IDLE.
REQ-026 Wait counter: cleared on entering ACCESS and incremented each ACCESS cycle without ack.
REQ-027 When the wait counter reaches TIMEOUT_CYCLES-1 without ack: next edge clears bus_req, pulses bus_err for 1 cycle, sets MemData_Mem=0 and Rd_write_byte_en_Mem=0, and goes to DONE.
REQ-028 flush during ACCESS SHALL NOT abort the bus transaction; it sets a drop flag.
REQ-029 On completion with the drop flag set: MemData_Mem=0 and Rd_write_byte_en_Mem=0, go to IDLE directly (skip DONE), and clear the drop flag.
REQ-030 bus_ack in IDLE or DONE SHALL be ignored.
REQ-031 bus_addr, bus_be, bus_we and bus_wdata SHALL stay stable while bus_req=1.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, clear the counter and drop flag, and set every registered output (bus_req, bus_we, bus_addr, bus_be, bus_wdata, MemData_Mem, Rd_write_byte_en_Mem, bus_err) to 0.
REQ-033 Reset mid-ACCESS SHALL drop bus_req with no completion; the combinational outputs mem_stall and addr_exc SHALL read 0 while rst_n=0.

Verification
REQ-034 lb, Addr=0x1003, bus_rdata=0x80FF_FF12, ack after 3 cycles -> mem_stall high 4 cycles, MemData_Mem=0xFFFFFF80, byte_en=1111, DONE 1 cycle.
REQ-035 sh, Addr=0x2002, StoreData=0x0000_BEEF -> bus_be=1100, bus_wdata=0xBEEF_BEEF, bus_we=1, bus_addr=0x2000, byte_en=0000.
REQ-036 lw, Addr=0x3001 -> addr_exc=1, bus_req stays 0, mem_stall=0.
REQ-037 lhu, Addr=0x4002, rdata=0x8001_0000, flush pulsed in the 2nd ACCESS cycle -> bus_req held until ack, then MemData_Mem=0, byte_en=0000, FSM goes ACCESS->IDLE.
REQ-038 TIMEOUT_CYCLES=4 with no ack -> bus_req high 4 cycles, bus_err 1-cycle pulse, DONE, byte_en=0000.
REQ-039 rst_n driven low asynchronously mid-ACCESS -> bus_req=0 and mem_stall=0 without a clock edge, all registered outputs 0.
